// File: rtl/audio_rcv_if.sv
// Stereo pair output bundle of the I2S receiver, plus status flags and FSM visibility.
// rx_left/rx_right transfer when rx_valid & rx_ready are high at a posedge; while rx_valid=1 and rx_ready=0 they stay unchanged.
interface audio_rcv_if #(
  parameter int WL = 16
);
  logic          rx_ready;
  logic [WL-1:0] rx_left;
  logic [WL-1:0] rx_right;
  logic          rx_valid;
  logic          rx_overrun;
  logic          frame_err;
  logic [1:0]    dbg_state;

  modport master (
    input  rx_ready,
    output rx_left, rx_right, rx_valid, rx_overrun, frame_err, dbg_state
  );

  modport slave (
    output rx_ready,
    input  rx_left, rx_right, rx_valid, rx_overrun, frame_err, dbg_state
  );
endinterface

// File: rtl/audio_rcv.sv
// I2S receiver for WM8978 ADC data: deserialises left/right slots on the bit clock
// and presents complete stereo pairs through a valid/ready handshake.
module audio_rcv #(
  parameter int WL = 16
) (
  input  logic        aud_bclk,
  input  logic        rst_n,
  input  logic        aud_lrc,
  input  logic        aud_adcdat,
  audio_rcv_if.master rx
);
  localparam int            CW   = $clog2(WL + 1);
  localparam logic [CW-1:0] LAST = CW'(WL - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_lrc_d0;
  logic [CW-1:0] r_cnt;
  logic          r_chan;
  logic [WL-2:0] r_shift;
  logic [WL-1:0] r_left_hold;
  logic          r_left_held;
  logic [WL-1:0] r_left;
  logic [WL-1:0] r_right;
  logic          r_valid;
  logic          r_overrun;
  logic          r_frame_err;

  logic          w_edge;
  logic          w_done;
  logic          w_short;
  logic          w_pair;
  logic [WL-1:0] w_word;

  // With a slot of exactly WL bclks the LSB arrives on the posedge that also sees
  // the next lrc edge, so a word with WL-1 bits already in is completed, not flagged.
  assign w_edge  = aud_lrc ^ r_lrc_d0;
  assign w_done  = (r_state == ST_SHIFT) && (r_cnt == LAST);
  assign w_short = (r_state == ST_SHIFT) && w_edge && !w_done;
  assign w_pair  = w_done && r_chan && r_left_held;
  assign w_word  = {r_shift, aud_adcdat};

  always_ff @(posedge aud_bclk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_lrc_d0    <= aud_lrc;
      r_cnt       <= '0;
      r_chan      <= 1'b0;
      r_shift     <= '0;
      r_left_hold <= '0;
      r_left_held <= 1'b0;
      r_left      <= '0;
      r_right     <= '0;
      r_valid     <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_lrc_d0    <= aud_lrc;
      r_frame_err <= w_short;

      case (r_state)
        ST_IDLE: begin
          if (w_edge) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_chan  <= aud_lrc;
          end
        end
        ST_SHIFT: begin
          if (w_edge) begin
            r_cnt  <= '0;
            r_chan <= aud_lrc;
          end else begin
            r_shift <= w_word[WL-2:0];
            r_cnt   <= r_cnt + CW'(1);
            if (w_done) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_edge) begin
            r_state <= ST_SHIFT;
            r_cnt   <= '0;
            r_chan  <= aud_lrc;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // A right word without a held left word, or a truncated slot, breaks the pair.
      if (w_done && !r_chan) begin
        r_left_hold <= w_word;
        r_left_held <= 1'b1;
      end else if (w_done || w_short) begin
        r_left_held <= 1'b0;
      end

      if (w_pair) begin
        if (!r_valid || rx.rx_ready) begin
          r_left  <= r_left_hold;
          r_right <= w_word;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && rx.rx_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign rx.rx_left    = r_left;
  assign rx.rx_right   = r_right;
  assign rx.rx_valid   = r_valid;
  assign rx.rx_overrun = r_overrun;
  assign rx.frame_err  = r_frame_err;
  assign rx.dbg_state  = r_state;
endmodule

// File: tb/tb_audio_rcv.sv
// Directed bench for audio_rcv: drives I2S slots on the falling bclk edge and
// checks pairs, handshake, overrun, frame errors and reset behaviour.
module tb_audio_rcv;
  localparam int WL = 16;

  logic aud_bclk   = 1'b0;
  logic rst_n      = 1'b0;
  logic aud_lrc    = 1'b1;
  logic aud_adcdat = 1'b0;
  logic carry_bit  = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int v_cnt    = 0;

  audio_rcv_if #(.WL(WL)) rx_if ();

  audio_rcv #(.WL(WL)) dut (
    .aud_bclk  (aud_bclk),
    .rst_n     (rst_n),
    .aud_lrc   (aud_lrc),
    .aud_adcdat(aud_adcdat),
    .rx        (rx_if.master)
  );

  // clock / reset
  always #5 aud_bclk = ~aud_bclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // monitor of output events, sampled on the falling edge
  always @(negedge aud_bclk) begin
    if (rx_if.frame_err) fe_cnt++;
    if (rx_if.rx_valid)  v_cnt++;
  end

  // driver: position 0 carries the previous slot's LSB (one-bclk I2S delay),
  // positions 1..WL carry the word MSB first, later positions are filler.
  task automatic slot_part(input logic lrc, input logic [WL-1:0] w, input int from, input int to);
    for (int i = from; i < to; i++) begin
      aud_lrc = lrc;
      if (i == 0)       aud_adcdat = carry_bit;
      else if (i <= WL) aud_adcdat = w[WL-i];
      else              aud_adcdat = 1'($urandom_range(0, 1));
      carry_bit = w[0];
      @(negedge aud_bclk);
    end
  endtask

  task automatic slot(input logic lrc, input logic [WL-1:0] w, input int len);
    slot_part(lrc, w, 0, len);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    aud_lrc = 1'b1;
    rx_if.rx_ready = 1'b1;
    repeat (4) @(negedge aud_bclk);
    n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b want 0", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_left !== 16'h0) begin n_fail++; $display("FAIL rst_left: got %h want 0000", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h0) begin n_fail++; $display("FAIL rst_right: got %h want 0000", rx_if.rx_right); end
    n_checks++; if (rx_if.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %0b want 0", rx_if.rx_overrun); end
    n_checks++; if (rx_if.frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %0b want 0", rx_if.frame_err); end
    n_checks++; if (rx_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", rx_if.dbg_state); end
    rst_n = 1'b1;
    @(negedge aud_bclk);
  endtask

  task automatic test_basic;
    rx_if.rx_ready = 1'b1;
    slot(1'b0, 16'hA5C3, 32);
    slot_part(1'b1, 16'h1234, 0, 17);
    n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %0b want 1", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_left !== 16'hA5C3) begin n_fail++; $display("FAIL basic_left: got %h want a5c3", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h1234) begin n_fail++; $display("FAIL basic_right: got %h want 1234", rx_if.rx_right); end
    slot_part(1'b1, 16'h1234, 17, 32);
    n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %0b want 0", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_left !== 16'hA5C3) begin n_fail++; $display("FAIL basic_left_hold: got %h want a5c3", rx_if.rx_left); end
  endtask

  task automatic test_back_to_back;
    rx_if.rx_ready = 1'b0;
    slot(1'b0, 16'h1111, 32);
    slot(1'b1, 16'h2222, 32);
    slot(1'b0, 16'h3333, 32);
    slot_part(1'b1, 16'h4444, 0, 16);
    n_checks++; if (rx_if.rx_right !== 16'h2222) begin n_fail++; $display("FAIL b2b_old_right: got %h want 2222", rx_if.rx_right); end
    rx_if.rx_ready = 1'b1;
    slot_part(1'b1, 16'h4444, 16, 17);
    n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b want 1", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_left !== 16'h3333) begin n_fail++; $display("FAIL b2b_left: got %h want 3333", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h4444) begin n_fail++; $display("FAIL b2b_right: got %h want 4444", rx_if.rx_right); end
    n_checks++; if (rx_if.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun: got %0b want 0", rx_if.rx_overrun); end
    slot_part(1'b1, 16'h4444, 17, 32);
    n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %0b want 0", rx_if.rx_valid); end
  endtask

  task automatic test_exact_slot;
    int fe0;
    fe0 = fe_cnt;
    rx_if.rx_ready = 1'b1;
    slot(1'b0, 16'h8001, 16);
    slot(1'b1, 16'h7FFE, 16);
    slot_part(1'b0, 16'h0000, 0, 1);
    n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL exact_valid: got %0b want 1", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_left !== 16'h8001) begin n_fail++; $display("FAIL exact_left: got %h want 8001", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h7FFE) begin n_fail++; $display("FAIL exact_right: got %h want 7ffe", rx_if.rx_right); end
    slot_part(1'b0, 16'h0000, 1, 32);
    slot(1'b1, 16'h0000, 32);
    n_checks++; if (fe_cnt !== fe0) begin n_fail++; $display("FAIL exact_frame_err: got %0d pulses want 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err;
    int fe0;
    int v0;
    rx_if.rx_ready = 1'b1;
    slot(1'b0, 16'h1357, 32);
    fe0 = fe_cnt;
    v0  = v_cnt;
    slot(1'b1, 16'h2468, 11);
    slot(1'b0, 16'hAAAA, 32);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - fe0); end
    n_checks++; if (v_cnt !== v0) begin n_fail++; $display("FAIL ferr_no_valid: got %0d valid cycles want 0", v_cnt - v0); end
    slot(1'b1, 16'h5555, 32);
    n_checks++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL ferr_next_valid: got %0d valid cycles want 1", v_cnt - v0); end
    n_checks++; if (rx_if.rx_left !== 16'hAAAA) begin n_fail++; $display("FAIL ferr_left: got %h want aaaa", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h5555) begin n_fail++; $display("FAIL ferr_right: got %h want 5555", rx_if.rx_right); end
  endtask

  task automatic test_overrun;
    rx_if.rx_ready = 1'b0;
    slot(1'b0, 16'hA5C3, 32);
    slot(1'b1, 16'h1234, 32);
    n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid1: got %0b want 1", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %0b want 0", rx_if.rx_overrun); end
    slot(1'b0, 16'h0F0F, 32);
    slot(1'b1, 16'hF0F0, 32);
    n_checks++; if (rx_if.rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid2: got %0b want 1", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_left !== 16'hA5C3) begin n_fail++; $display("FAIL ovr_left: got %h want a5c3", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h1234) begin n_fail++; $display("FAIL ovr_right: got %h want 1234", rx_if.rx_right); end
    n_checks++; if (rx_if.rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %0b want 1", rx_if.rx_overrun); end
    rx_if.rx_ready = 1'b1;
    @(negedge aud_bclk);
    n_checks++; if (rx_if.rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain: got %0b want 0", rx_if.rx_valid); end
    n_checks++; if (rx_if.rx_overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %0b want 1", rx_if.rx_overrun); end
  endtask

  task automatic test_reset_mid;
    int v0;
    rx_if.rx_ready = 1'b1;
    slot_part(1'b0, 16'hBEEF, 0, 8);
    rst_n = 1'b0;
    slot_part(1'b0, 16'hBEEF, 8, 20);
    n_checks++; if (rx_if.rx_left !== 16'h0) begin n_fail++; $display("FAIL rmid_left: got %h want 0000", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'h0) begin n_fail++; $display("FAIL rmid_right: got %h want 0000", rx_if.rx_right); end
    n_checks++; if (rx_if.rx_overrun !== 1'b0) begin n_fail++; $display("FAIL rmid_overrun: got %0b want 0", rx_if.rx_overrun); end
    n_checks++; if (rx_if.dbg_state !== 2'd0) begin n_fail++; $display("FAIL rmid_state: got %0d want 0", rx_if.dbg_state); end
    rst_n = 1'b1;
    v0 = v_cnt;
    slot_part(1'b0, 16'hBEEF, 20, 32);
    slot(1'b1, 16'hCAFE, 32);
    n_checks++; if (v_cnt !== v0) begin n_fail++; $display("FAIL rmid_orphan_right: got %0d valid cycles want 0", v_cnt - v0); end
    slot(1'b0, 16'h6789, 32);
    slot(1'b1, 16'hABCD, 32);
    n_checks++; if (v_cnt - v0 !== 1) begin n_fail++; $display("FAIL rmid_valid: got %0d valid cycles want 1", v_cnt - v0); end
    n_checks++; if (rx_if.rx_left !== 16'h6789) begin n_fail++; $display("FAIL rmid_left2: got %h want 6789", rx_if.rx_left); end
    n_checks++; if (rx_if.rx_right !== 16'hABCD) begin n_fail++; $display("FAIL rmid_right2: got %h want abcd", rx_if.rx_right); end
  endtask

  initial begin
    rx_if.rx_ready = 1'b1;
    @(negedge aud_bclk);
    test_reset();
    test_basic();
    test_back_to_back();
    test_exact_slot();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
